// File: rtl/sram2tlul_buf.sv
// sram2tlul_buf: SRAM req/gnt master to TL-UL host adapter with request FIFO and in-order tag tracking
package top_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AUW = 16;
    localparam int TL_DUW = 16;
endpackage

package tlul_pkg;
    import top_pkg::*;
    typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
    typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;
    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_AUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t;
    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

module sram2tlul_buf #(
    parameter int                          SramAw         = 12,
    parameter int                          SramDw         = 32,
    parameter logic [top_pkg::TL_AW-1:0]   TlBaseAddr     = '0,
    parameter int                          ReqFifoDepth   = 2,
    parameter int                          MaxOutstanding = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output tlul_pkg::tl_h2d_t     tl_o,
    input  tlul_pkg::tl_d2h_t     tl_i,
    input  logic                  mem_req_i,
    output logic                  mem_gnt_o,
    input  logic                  mem_write_i,
    input  logic [SramAw-1:0]     mem_addr_i,
    input  logic [SramDw-1:0]     mem_wdata_i,
    input  logic [SramDw/8-1:0]   mem_wmask_i,
    output logic                  mem_rvalid_o,
    output logic                  mem_wack_o,
    output logic [SramDw-1:0]     mem_rdata_o,
    output logic [1:0]            mem_error_o
);
    localparam int Off = $clog2(SramDw / 8);
    localparam int MW  = SramDw / 8;
    localparam int PW  = ReqFifoDepth > 1 ? $clog2(ReqFifoDepth) : 1;
    localparam int CW  = $clog2(ReqFifoDepth + 1);
    localparam int TW  = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
    localparam int OW  = $clog2(MaxOutstanding + 1);

    if (SramDw != top_pkg::TL_DW || ReqFifoDepth < 1 || MaxOutstanding < 1) begin : g_param_check
        $error("sram2tlul_buf: illegal parameterisation");
    end

    typedef struct packed {
        logic              write;
        logic [SramAw-1:0] addr;
        logic [SramDw-1:0] wdata;
        logic [MW-1:0]     wmask;
    } req_t;

    req_t                  fifo_q [ReqFifoDepth];
    req_t                  head;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [OW-1:0]         outstanding;
    logic [TW-1:0]         issue_tag, exp_tag;
    logic [MaxOutstanding-1:0] type_q;
    logic                  full, empty, push, a_valid, a_hs, solicited, exp_write, src_bad, op_bad;
    logic                  unused_d;

    assign unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

    always_comb begin
        head      = fifo_q[rd_ptr];
        full      = count == CW'(ReqFifoDepth);
        empty     = count == '0;
        mem_gnt_o = !full && !rst_i;
        push      = mem_req_i && mem_gnt_o;
        a_valid   = !empty && outstanding < OW'(MaxOutstanding);
        a_hs      = a_valid && tl_i.a_ready;
        solicited = tl_i.d_valid && outstanding != '0;
        exp_write = type_q[exp_tag];
        src_bad   = tl_i.d_source != top_pkg::TL_AIW'(exp_tag);
        op_bad    = tl_i.d_opcode != (exp_write ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData);
        tl_o           = '0;
        tl_o.a_valid   = a_valid;
        tl_o.a_opcode  = !head.write ? tlul_pkg::Get :
                         &head.wmask ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
        tl_o.a_size    = top_pkg::TL_SZW'(Off);
        tl_o.a_source  = top_pkg::TL_AIW'(issue_tag);
        tl_o.a_address = TlBaseAddr | top_pkg::TL_AW'({head.addr, Off'(0)});
        tl_o.a_mask    = head.write ? head.wmask : '1;
        tl_o.a_data    = head.wdata;
        tl_o.d_ready   = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr] <= '{mem_write_i, mem_addr_i, mem_wdata_i, mem_wmask_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            outstanding  <= '0;
            issue_tag    <= '0;
            exp_tag      <= '0;
            type_q       <= '0;
            mem_rvalid_o <= 1'b0;
            mem_wack_o   <= 1'b0;
            mem_rdata_o  <= '0;
            mem_error_o  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PW'(ReqFifoDepth - 1) ? '0 : wr_ptr + 1'b1;
            if (a_hs) rd_ptr <= rd_ptr == PW'(ReqFifoDepth - 1) ? '0 : rd_ptr + 1'b1;
            count       <= count + CW'(push) - CW'(a_hs);
            outstanding <= outstanding + OW'(a_hs) - OW'(solicited);
            if (a_hs) begin
                type_q[issue_tag] <= head.write;
                issue_tag         <= issue_tag == TW'(MaxOutstanding - 1) ? '0 : issue_tag + 1'b1;
            end
            if (solicited) exp_tag <= exp_tag == TW'(MaxOutstanding - 1) ? '0 : exp_tag + 1'b1;
            mem_rvalid_o <= tl_i.d_valid && !(solicited && exp_write);
            mem_wack_o   <= solicited && exp_write;
            // beats with nothing outstanding are reported as reads with a protocol error
            if (tl_i.d_valid) begin
                mem_rdata_o <= !solicited ? '0 : exp_write ? mem_rdata_o : tl_i.d_data;
                mem_error_o <= solicited ? {src_bad || op_bad, tl_i.d_error} : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_sram2tlul_buf.sv
// tb_sram2tlul_buf: directed self-checking bench for the SRAM-to-TL-UL adapter
module tb_sram2tlul_buf;
    import tlul_pkg::*;
    localparam logic [31:0] Base = 32'h1000_0000;

    logic        clk, rst;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;
    logic        mem_req, mem_gnt, mem_write, mem_rvalid, mem_wack;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic [1:0]  mem_error;
    int          checks, errors;

    sram2tlul_buf #(.TlBaseAddr(Base)) dut (
        .clk_i(clk), .rst_i(rst), .tl_o(tl_o), .tl_i(tl_i),
        .mem_req_i(mem_req), .mem_gnt_o(mem_gnt), .mem_write_i(mem_write),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_wmask_i(mem_wmask),
        .mem_rvalid_o(mem_rvalid), .mem_wack_o(mem_wack), .mem_rdata_o(mem_rdata),
        .mem_error_o(mem_error)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic wr, input logic [11:0] addr, input logic [31:0] data, input logic [3:0] mask);
        mem_req = 1; mem_write = wr; mem_addr = addr; mem_wdata = data; mem_wmask = mask;
        step();
        mem_req = 0;
    endtask

    task automatic d_beat(input tl_d_op_e op, input logic [7:0] src, input logic [31:0] data, input logic err);
        tl_i.d_valid = 1; tl_i.d_opcode = op; tl_i.d_source = src; tl_i.d_data = data; tl_i.d_error = err;
        step();
        tl_i.d_valid = 0; tl_i.d_error = 0;
    endtask

    task automatic issue();
        tl_i.a_ready = 1;
        step();
        tl_i.a_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; step(); step(); rst = 0; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got %h want 1", mem_gnt); end
        checks++; if (tl_o.a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %h want 0", tl_o.a_valid); end
        checks++; if (tl_o.d_ready !== 1'b1) begin errors++; $display("FAIL reset_d_ready got %h want 1", tl_o.d_ready); end
        checks++; if ({mem_rvalid, mem_wack, mem_error} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {mem_rvalid, mem_wack, mem_error}); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
    endtask

    task automatic test_single_read();
        push(0, 12'h010, 32'h0, 4'h0);
        checks++; if (tl_o.a_valid !== 1'b1) begin errors++; $display("FAIL rd_a_valid got %h want 1", tl_o.a_valid); end
        checks++; if (tl_o.a_address !== 32'h1000_0040) begin errors++; $display("FAIL rd_addr got %h want 10000040", tl_o.a_address); end
        checks++; if (tl_o.a_opcode !== Get) begin errors++; $display("FAIL rd_opcode got %h want 4", tl_o.a_opcode); end
        checks++; if (tl_o.a_mask !== 4'hF) begin errors++; $display("FAIL rd_mask got %h want f", tl_o.a_mask); end
        checks++; if (tl_o.a_source !== 8'd0) begin errors++; $display("FAIL rd_source got %h want 0", tl_o.a_source); end
        checks++; if (tl_o.a_size !== 2'd2) begin errors++; $display("FAIL rd_size got %h want 2", tl_o.a_size); end
        issue();
        checks++; if (tl_o.a_valid !== 1'b0) begin errors++; $display("FAIL rd_a_valid_after got %h want 0", tl_o.a_valid); end
        d_beat(AccessAckData, 8'd0, 32'hDEAD_BEEF, 0);
        checks++; if ({mem_rvalid, mem_wack} !== 2'b10) begin errors++; $display("FAIL rd_pulse got %b want 10", {mem_rvalid, mem_wack}); end
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", mem_rdata); end
        checks++; if (mem_error !== 2'b00) begin errors++; $display("FAIL rd_error got %b want 00", mem_error); end
        step();
        checks++; if (mem_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse_end got %h want 0", mem_rvalid); end
    endtask

    task automatic test_partial_write();
        push(1, 12'h020, 32'h1234_5678, 4'b0011);
        checks++; if (tl_o.a_opcode !== PutPartialData) begin errors++; $display("FAIL wr_opcode got %h want 1", tl_o.a_opcode); end
        checks++; if (tl_o.a_mask !== 4'h3) begin errors++; $display("FAIL wr_mask got %h want 3", tl_o.a_mask); end
        checks++; if (tl_o.a_data !== 32'h1234_5678) begin errors++; $display("FAIL wr_data got %h want 12345678", tl_o.a_data); end
        checks++; if (tl_o.a_address !== 32'h1000_0080) begin errors++; $display("FAIL wr_addr got %h want 10000080", tl_o.a_address); end
        checks++; if (tl_o.a_source !== 8'd1) begin errors++; $display("FAIL wr_source got %h want 1", tl_o.a_source); end
        issue();
        d_beat(AccessAck, 8'd1, 32'hFFFF_FFFF, 0);
        checks++; if ({mem_rvalid, mem_wack} !== 2'b01) begin errors++; $display("FAIL wr_pulse got %b want 01", {mem_rvalid, mem_wack}); end
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rdata_hold got %h want deadbeef", mem_rdata); end
        checks++; if (mem_error !== 2'b00) begin errors++; $display("FAIL wr_error got %b want 00", mem_error); end
    endtask

    task automatic test_backpressure();
        mem_req = 1; mem_write = 0; mem_addr = 12'h1; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt0 got %h want 1", mem_gnt); end
        step();
        mem_addr = 12'h2; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt1 got %h want 1", mem_gnt); end
        step();
        mem_addr = 12'h3;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (mem_gnt !== 1'b0) begin errors++; $display("FAIL bp_full_gnt[%0d] got %h want 0", i, mem_gnt); end
            checks++; if (tl_o.a_valid !== 1'b1 || tl_o.a_address !== Base + 32'h4) begin errors++; $display("FAIL bp_stable[%0d] got %h/%h want 1/%h", i, tl_o.a_valid, tl_o.a_address, Base + 32'h4); end
            step();
        end
        tl_i.a_ready = 1;
        step();
        checks++; if (tl_o.a_address !== Base + 32'h8 || tl_o.a_source !== 8'd1) begin errors++; $display("FAIL bp_second got %h/%h want %h/1", tl_o.a_address, tl_o.a_source, Base + 32'h8); end
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt_free got %h want 1", mem_gnt); end
        step();
        mem_req = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (tl_o.a_valid !== 1'b0) begin errors++; $display("FAIL bp_blocked[%0d] got %h want 0", i, tl_o.a_valid); end
            step();
        end
        d_beat(AccessAckData, 8'd0, 32'h1111, 0);
        checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h1111) begin errors++; $display("FAIL bp_resp0 got %h/%h want 1/1111", mem_rvalid, mem_rdata); end
        checks++; if (tl_o.a_valid !== 1'b1 || tl_o.a_source !== 8'd0 || tl_o.a_address !== Base + 32'hC) begin errors++; $display("FAIL bp_third got %h/%h/%h want 1/0/%h", tl_o.a_valid, tl_o.a_source, tl_o.a_address, Base + 32'hC); end
        step();
        tl_i.a_ready = 0;
        d_beat(AccessAckData, 8'd1, 32'h2222, 0);
        checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h2222 || mem_error !== 2'b00) begin errors++; $display("FAIL bp_resp1 got %h/%h/%b want 1/2222/00", mem_rvalid, mem_rdata, mem_error); end
        d_beat(AccessAckData, 8'd0, 32'h3333, 0);
        checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h3333 || mem_error !== 2'b00) begin errors++; $display("FAIL bp_resp2 got %h/%h/%b want 1/3333/00", mem_rvalid, mem_rdata, mem_error); end
    endtask

    task automatic test_back_to_back();
        rst = 1; step(); rst = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            mem_req = cyc < 4; mem_write = 0; mem_addr = 12'(4 + cyc);
            tl_i.a_ready = 1; tl_i.d_valid = cyc >= 2 && cyc <= 5;
            tl_i.d_opcode = AccessAckData; tl_i.d_source = {7'b0, cyc[0]}; tl_i.d_data = 32'(32'hA0 + cyc - 2);
            #1;
            if (cyc >= 1 && cyc <= 4) begin
                checks++; if (tl_o.a_valid !== 1'b1 || tl_o.a_address !== Base + 32'((4 + cyc - 1) * 4)) begin errors++; $display("FAIL b2b_a[%0d] got %h/%h want 1/%h", cyc, tl_o.a_valid, tl_o.a_address, Base + 32'((4 + cyc - 1) * 4)); end
                checks++; if (tl_o.a_source !== {7'b0, !cyc[0]}) begin errors++; $display("FAIL b2b_src[%0d] got %h want %h", cyc, tl_o.a_source, !cyc[0]); end
            end
            if (cyc >= 3) begin
                checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'(32'hA0 + cyc - 3)) begin errors++; $display("FAIL b2b_resp[%0d] got %h/%h want 1/%h", cyc, mem_rvalid, mem_rdata, 32'(32'hA0 + cyc - 3)); end
                checks++; if (mem_error !== 2'b00) begin errors++; $display("FAIL b2b_err[%0d] got %b want 00", cyc, mem_error); end
            end
            step();
        end
        mem_req = 0; tl_i.a_ready = 0; tl_i.d_valid = 0;
    endtask

    task automatic test_errors();
        push(0, 12'h8, 32'h0, 4'h0);
        issue();
        d_beat(AccessAckData, 8'd1, 32'h55, 0);
        checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h55 || mem_error !== 2'b10) begin errors++; $display("FAIL err_src got %h/%h/%b want 1/55/10", mem_rvalid, mem_rdata, mem_error); end
        push(1, 12'h9, 32'hCAFE, 4'hF);
        checks++; if (tl_o.a_opcode !== PutFullData || tl_o.a_mask !== 4'hF || tl_o.a_source !== 8'd1) begin errors++; $display("FAIL err_full got %h/%h/%h want 0/f/1", tl_o.a_opcode, tl_o.a_mask, tl_o.a_source); end
        issue();
        d_beat(AccessAckData, 8'd1, 32'h77, 0);
        checks++; if ({mem_rvalid, mem_wack} !== 2'b01 || mem_rdata !== 32'h55 || mem_error !== 2'b10) begin errors++; $display("FAIL err_op got %b/%h/%b want 01/55/10", {mem_rvalid, mem_wack}, mem_rdata, mem_error); end
        d_beat(AccessAckData, 8'd0, 32'h99, 0);
        checks++; if ({mem_rvalid, mem_wack} !== 2'b10 || mem_rdata !== 32'h0 || mem_error !== 2'b10) begin errors++; $display("FAIL err_unsol got %b/%h/%b want 10/0/10", {mem_rvalid, mem_wack}, mem_rdata, mem_error); end
        step();
        checks++; if ({mem_rvalid, mem_wack} !== 2'b00 || mem_error !== 2'b10) begin errors++; $display("FAIL err_hold got %b/%b want 00/10", {mem_rvalid, mem_wack}, mem_error); end
        push(0, 12'hA, 32'h0, 4'h0);
        checks++; if (tl_o.a_source !== 8'd0) begin errors++; $display("FAIL err_tag_kept got %h want 0", tl_o.a_source); end
        issue();
        d_beat(AccessAckData, 8'd0, 32'hAB, 0);
        checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'hAB || mem_error !== 2'b00) begin errors++; $display("FAIL err_recover got %h/%h/%b want 1/ab/00", mem_rvalid, mem_rdata, mem_error); end
    endtask

    task automatic test_reset_mid();
        mem_req = 1; mem_write = 0; mem_addr = 12'h9; step();
        mem_addr = 12'hA; tl_i.a_ready = 1; step();
        mem_addr = 12'hB; step();
        mem_req = 0; #1;
        checks++; if (tl_o.a_valid !== 1'b0) begin errors++; $display("FAIL rm_blocked got %h want 0", tl_o.a_valid); end
        rst = 1; #1;
        checks++; if (mem_gnt !== 1'b0) begin errors++; $display("FAIL rm_gnt_in_reset got %h want 0", mem_gnt); end
        step();
        rst = 0; tl_i.a_ready = 0; #1;
        checks++; if (mem_gnt !== 1'b1 || tl_o.a_valid !== 1'b0) begin errors++; $display("FAIL rm_after got %h/%h want 1/0", mem_gnt, tl_o.a_valid); end
        checks++; if ({mem_rvalid, mem_wack, mem_error} !== 4'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL rm_outputs got %b/%h want 0000/0", {mem_rvalid, mem_wack, mem_error}, mem_rdata); end
        d_beat(AccessAckData, 8'd0, 32'h42, 0);
        checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h0 || mem_error !== 2'b10) begin errors++; $display("FAIL rm_late got %h/%h/%b want 1/0/10", mem_rvalid, mem_rdata, mem_error); end
        push(0, 12'h3F, 32'h0, 4'h0);
        checks++; if (tl_o.a_valid !== 1'b1 || tl_o.a_source !== 8'd0 || tl_o.a_address !== 32'h1000_00FC) begin errors++; $display("FAIL rm_new got %h/%h/%h want 1/0/100000fc", tl_o.a_valid, tl_o.a_source, tl_o.a_address); end
        issue();
        d_beat(AccessAckData, 8'd0, 32'hBEEF, 1);
        checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'hBEEF || mem_error !== 2'b01) begin errors++; $display("FAIL rm_derr got %h/%h/%b want 1/beef/01", mem_rvalid, mem_rdata, mem_error); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1; tl_i = '0; mem_req = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
        test_reset();
        test_single_read();
        test_partial_write();
        test_backpressure();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
